// File: rtl/fsm_pkg.sv
// Shared types for the 4-state FSM encoders and the receive-side decoder:
// encoding selector, state index, lock-state enum and the reference codeword mapping.
package fsm_pkg;

  typedef enum logic [1:0] {
    ENC_BINARY     = 2'd0,
    ENC_ONEHOT     = 2'd1,
    ENC_ONEHOT_REV = 2'd2
  } enc_t;

  localparam int NUM_STATES = 4;

  typedef logic [1:0] state_idx_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Codeword an encoder emits for state idx; the decoder inverts this same mapping.
  function automatic logic [3:0] encode_state(input state_idx_t idx, input enc_t enc);
    logic [3:0] code;
    case (enc)
      ENC_BINARY:     code = {2'b00, idx};
      ENC_ONEHOT:     code = 4'b0001 << idx;
      ENC_ONEHOT_REV: code = 4'b1000 >> idx;
      default:        code = 4'b0000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fsm_code_decode.sv
// Combinational codeword decoder: a code is legal only if it matches the
// codeword of exactly one state for the selected encoding.
module fsm_code_decode
  import fsm_pkg::*;
#(
  parameter int ENCODING = 0
) (
  input  logic [3:0] code_i,
  output logic       legal_o,
  output state_idx_t idx_o
);

  localparam enc_t ENC = enc_t'(ENCODING);

  logic hit_s;

  // Match the code against every state's codeword; codewords are distinct so at most one hits.
  always_comb begin
    legal_o = 1'b0;
    idx_o   = 2'd0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_STATES; i++) begin
      hit_s   = (code_i == encode_state(state_idx_t'(i), ENC));
      legal_o = legal_o | hit_s;
      idx_o   = hit_s ? state_idx_t'(i) : idx_o;
    end
  end

endmodule

// File: rtl/fsm_state_decoder.sv
// Receive-side checker for the 4-state FSM encoders: decodes the state index,
// recovers the 'in' bit, flags illegal codes / transitions, tracks lock, counts errors.
module fsm_state_decoder
  import fsm_pkg::*;
#(
  parameter int ENCODING   = 0,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [3:0]           code,
  output logic [1:0]           state_idx,
  output logic                 idx_valid,
  output logic                 in_recovered,
  output logic                 in_valid,
  output logic                 illegal_code,
  output logic                 bad_transition,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

  logic        legal_s;
  state_idx_t  dec_idx_s;
  logic        hold_s;
  logic        adv_s;
  logic        bad_s;
  logic        err_s;

  state_idx_t             state_idx_q;
  state_idx_t             prev_q;
  logic                   prev_valid_q;
  logic                   idx_valid_q;
  logic                   in_rec_q;
  logic                   in_valid_q;
  logic                   illegal_q;
  logic                   bad_q;
  logic                   locked_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  lock_state_t            lock_q;
  logic [3:0]             consec_q;

  fsm_code_decode #(.ENCODING(ENCODING)) u_code_decode (
    .code_i  (code),
    .legal_o (legal_s),
    .idx_o   (dec_idx_s)
  );

  // Classify the sample against the previous legal state; only meaningful when prev is valid.
  always_comb begin
    hold_s = legal_s && prev_valid_q && (dec_idx_s == prev_q);
    adv_s  = legal_s && prev_valid_q && (dec_idx_s == state_idx_t'(prev_q + 2'd1));
    bad_s  = legal_s && prev_valid_q && !hold_s && !adv_s;
    err_s  = !legal_s || bad_s;
  end

  // Sample register, transition result pulses, saturating error counter and lock FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_idx_q  <= 2'd0;
      prev_q       <= 2'd0;
      prev_valid_q <= 1'b0;
      idx_valid_q  <= 1'b0;
      in_rec_q     <= 1'b0;
      in_valid_q   <= 1'b0;
      illegal_q    <= 1'b0;
      bad_q        <= 1'b0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
      lock_q       <= UNLOCKED;
      consec_q     <= 4'd0;
    end else if (en) begin
      idx_valid_q <= legal_s;
      illegal_q   <= !legal_s;
      bad_q       <= bad_s;
      in_valid_q  <= hold_s || adv_s;
      in_rec_q    <= adv_s;
      if (legal_s) begin
        state_idx_q  <= dec_idx_s;
        prev_q       <= dec_idx_s;
        prev_valid_q <= 1'b1;
      end else begin
        prev_valid_q <= 1'b0;
      end
      if (err_s && (err_count_q != ERR_MAX)) begin
        err_count_q <= err_count_q + ERR_ONE;
      end else begin
        err_count_q <= err_count_q;
      end
      case (lock_q)
        UNLOCKED: begin
          locked_q <= 1'b0;
          if (!err_s) begin
            lock_q   <= ACQUIRE;
            consec_q <= 4'd0;
          end else begin
            lock_q <= UNLOCKED;
          end
        end
        ACQUIRE: begin
          if (err_s) begin
            lock_q   <= UNLOCKED;
            consec_q <= 4'd0;
            locked_q <= 1'b0;
          end else if (hold_s || adv_s) begin
            consec_q <= consec_q + 4'd1;
            lock_q   <= ((consec_q + 4'd1) == LOCK_N) ? LOCKED : ACQUIRE;
            locked_q <= ((consec_q + 4'd1) == LOCK_N);
          end else begin
            lock_q <= ACQUIRE;
          end
        end
        LOCKED: begin
          // locked drops on the same edge the error pulse is registered.
          if (err_s) begin
            lock_q   <= UNLOCKED;
            consec_q <= 4'd0;
            locked_q <= 1'b0;
          end else begin
            lock_q   <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        default: begin
          lock_q   <= UNLOCKED;
          consec_q <= 4'd0;
          locked_q <= 1'b0;
        end
      endcase
    end else begin
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      bad_q       <= 1'b0;
      in_valid_q  <= 1'b0;
      in_rec_q    <= 1'b0;
    end
  end

  assign state_idx      = state_idx_q;
  assign idx_valid      = idx_valid_q;
  assign in_recovered   = in_rec_q;
  assign in_valid       = in_valid_q;
  assign illegal_code   = illegal_q;
  assign bad_transition = bad_q;
  assign locked         = locked_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_fsm_state_decoder.sv
// Runs one decoder per encoding on the same abstract symbol stream and checks
// all of them against a single behavioural model of the receive rules.
module tb_fsm_state_decoder;

  localparam int LOCK_COUNT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] code_a [3];
  logic [1:0] st_a   [3];
  logic       iv_a   [3];
  logic       rec_a  [3];
  logic       inv_a  [3];
  logic       ill_a  [3];
  logic       bad_a  [3];
  logic       lck_a  [3];
  logic [7:0] ec_a   [3];

  int tests  = 0;
  int failed = 0;

  // Reference model state
  int m_idx, m_prev, m_err, m_lock, m_consec;
  bit m_pv, m_iv, m_rec, m_inv, m_ill, m_bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fsm_state_decoder #(.ENCODING(g), .LOCK_COUNT(LOCK_COUNT), .ERR_CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .en(en), .code(code_a[g]),
      .state_idx(st_a[g]), .idx_valid(iv_a[g]), .in_recovered(rec_a[g]),
      .in_valid(inv_a[g]), .illegal_code(ill_a[g]), .bad_transition(bad_a[g]),
      .locked(lck_a[g]), .err_count(ec_a[g])
    );
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_prev = 0; m_err = 0; m_lock = 0; m_consec = 0;
    m_pv = 0; m_iv = 0; m_rec = 0; m_inv = 0; m_ill = 0; m_bad = 0;
  endtask

  // Receive rules: delta 0 = hold, 1 = advance, anything else is a bad transition.
  task automatic model_step(input bit rst, input bit e, input bit ok, input int idx);
    int  delta;
    bit  err;
    if (rst) begin
      model_reset();
    end else if (e) begin
      delta = (idx - m_prev + 4) % 4;
      m_ill = !ok;
      m_bad = ok && m_pv && (delta > 1);
      m_inv = ok && m_pv && (delta <= 1);
      m_rec = m_inv && (delta == 1);
      m_iv  = ok;
      err   = m_ill || m_bad;
      if (err && m_err < 255) m_err++;
      if (err) begin
        m_lock = 0; m_consec = 0;
      end else if (m_lock == 0) begin
        m_lock = 1; m_consec = 0;
      end else if (m_lock == 1 && m_inv) begin
        m_consec++;
        if (m_consec == LOCK_COUNT) m_lock = 2;
      end
      if (ok) begin
        m_idx = idx; m_prev = idx; m_pv = 1;
      end else begin
        m_pv = 0;
      end
    end else begin
      m_iv = 0; m_rec = 0; m_inv = 0; m_ill = 0; m_bad = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("state_idx[%0d]", d),      int'(st_a[d]),  m_idx);
      check($sformatf("idx_valid[%0d]", d),      int'(iv_a[d]),  int'(m_iv));
      check($sformatf("in_recovered[%0d]", d),   int'(rec_a[d]), int'(m_rec));
      check($sformatf("in_valid[%0d]", d),       int'(inv_a[d]), int'(m_inv));
      check($sformatf("illegal_code[%0d]", d),   int'(ill_a[d]), int'(m_ill));
      check($sformatf("bad_transition[%0d]", d), int'(bad_a[d]), int'(m_bad));
      check($sformatf("locked[%0d]", d),         int'(lck_a[d]), int'(m_lock == 2));
      check($sformatf("err_count[%0d]", d),      int'(ec_a[d]),  m_err);
    end
  endtask

  // Apply one symbol (legal state idx, or explicit per-encoding illegal codes) for one edge.
  task automatic step(input bit rst, input bit e, input bit ok, input int idx,
                      input logic [3:0] ib, input logic [3:0] io, input logic [3:0] ir);
    reset = rst;
    en    = e;
    if (ok) begin
      code_a[0] = 4'(idx);
      code_a[1] = 4'(1 << idx);
      code_a[2] = 4'(8 >> idx);
    end else begin
      code_a[0] = ib; code_a[1] = io; code_a[2] = ir;
    end
    @(posedge clk);
    model_step(rst, e, ok, idx);
    #1;
    check_all();
  endtask

  task automatic sym(input int idx);
    step(1'b0, 1'b1, 1'b1, idx, 4'd0, 4'd0, 4'd0);
  endtask

  // Random illegal codeword for every encoding.
  task automatic rand_illegal();
    logic [3:0] b, o, r;
    b = {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
    do o = 4'($urandom_range(0, 15)); while ($countones(o) == 1);
    do r = 4'($urandom_range(0, 15)); while ($countones(r) == 1);
    step(1'b0, 1'b1, 1'b0, 0, b, o, r);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0;
    for (int d = 0; d < 3; d++) code_a[d] = 4'd0;
    model_reset();

    // Reset, then an advancing stream across all encodings
    step(1'b1, 1'b0, 1'b1, 0, 4'd0, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) sym(k % 4);
    check("locked_after_stream", int'(lck_a[0]), 1);
    check("err_after_stream", int'(ec_a[1]), 0);

    // Hold at S3 while locked, then skip S1 -> S3 and relock
    for (int k = 0; k < 3; k++) sym(3);
    sym(0); sym(1); sym(3);
    check("bad_transition_skip", int'(bad_a[2]), 1);
    check("locked_drop_on_skip", int'(lck_a[0]), 0);
    sym(0); sym(1); sym(2);
    check("relock", int'(lck_a[1]), 1);

    // Illegal codes after a fresh reset
    step(1'b1, 1'b1, 1'b1, 0, 4'd0, 4'd0, 4'd0);
    sym(0);
    step(1'b0, 1'b1, 1'b0, 0, 4'b0110, 4'b0110, 4'b0110);
    step(1'b0, 1'b1, 1'b0, 0, 4'b1000, 4'b0000, 4'b0000);
    check("err_two_illegal", int'(ec_a[1]), 2);
    sym(1);
    check("in_valid_after_illegal", int'(inv_a[1]), 0);

    // en low: pulses clear, state holds
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 3, 4'd0, 4'd0, 4'd0);

    // Saturate the error counter, then reset mid-stream
    while (m_err < 254) rand_illegal();
    for (int k = 0; k < 3; k++) rand_illegal();
    check("err_saturated", int'(ec_a[0]), 255);
    step(1'b1, 1'b1, 1'b0, 0, 4'b1111, 4'b1111, 4'b1111);
    check("reset_err_clear", int'(ec_a[2]), 0);

    // Randomised stream biased toward hold/advance
    for (int k = 0; k < 600; k++) begin
      int r, nxt;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 0, 4'd0, 4'd0, 4'd0);
      end else if (r < 12) begin
        step(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 3)), 4'd0, 4'd0, 4'd0);
      end else if (r < 18) begin
        rand_illegal();
      end else begin
        if (r < 45)      nxt = m_prev;
        else if (r < 88) nxt = (m_prev + 1) % 4;
        else             nxt = int'($urandom_range(0, 3));
        sym(nxt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
